// File: rtl/buffer_mem_wb_skid.sv
// buffer_mem_wb_skid: MEM/WB pipeline buffer with a valid/ready handshake and
// a 2-entry skid buffer (main + skid register). in_ready is registered, so a
// write-back stall never forms a combinational path back into the MEM stage.
// A synchronous flush empties the buffer. out_wb is forced to zero on bubbles
// so an invalid slot can never write the register file.
// Optional feature macro: MEMWB_STATS_EN adds a saturating stall counter
// (stall_count, STAT_W bits) counting cycles with out_valid=1 and out_ready=0.

module buffer_mem_wb_skid #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2
`ifdef MEMWB_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [REG_W-1:0]  in_dest_reg,
  input  logic [WB_W-1:0]   in_wb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_read_data,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [REG_W-1:0]  out_dest_reg,
  output logic [WB_W-1:0]   out_wb
`ifdef MEMWB_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_count
`endif
);

  // Occupancy of the buffer: nothing held, main only, main and skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_out_valid;

  logic [DATA_W-1:0] r_main_read_data;
  logic [DATA_W-1:0] r_main_alu_result;
  logic [REG_W-1:0]  r_main_dest_reg;
  logic [WB_W-1:0]   r_main_wb;

  logic [DATA_W-1:0] r_skid_read_data;
  logic [DATA_W-1:0] r_skid_alu_result;
  logic [REG_W-1:0]  r_skid_dest_reg;
  logic [WB_W-1:0]   r_skid_wb;

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_load_main_from_in;
  logic              w_load_main_from_skid;
  logic              w_load_skid;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // Main takes the input when it is empty or is being drained in the same
  // cycle; otherwise a new input parks in the skid register. In FULL the
  // skid entry moves up into main as soon as main is consumed.
  assign w_load_main_from_in   = w_in_fire &
                                 ((r_state == ST_EMPTY) |
                                  ((r_state == ST_ONE) & w_out_fire));
  assign w_load_main_from_skid = (r_state == ST_FULL) & w_out_fire;
  assign w_load_skid           = (r_state == ST_ONE) & w_in_fire & ~w_out_fire;

  // Occupancy FSM with registered in_ready/out_valid; flush beats everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_out_fire && !w_in_fire) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end else if (w_in_fire && !w_out_fire) begin
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b0;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Main register: the entry currently presented to write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_read_data  <= '0;
      r_main_alu_result <= '0;
      r_main_dest_reg   <= '0;
      r_main_wb         <= '0;
    end else if (flush) begin
      r_main_wb         <= '0;
    end else if (w_load_main_from_in) begin
      r_main_read_data  <= in_read_data;
      r_main_alu_result <= in_alu_result;
      r_main_dest_reg   <= in_dest_reg;
      r_main_wb         <= in_wb;
    end else if (w_load_main_from_skid) begin
      r_main_read_data  <= r_skid_read_data;
      r_main_alu_result <= r_skid_alu_result;
      r_main_dest_reg   <= r_skid_dest_reg;
      r_main_wb         <= r_skid_wb;
    end
  end

  // Skid register: catches the one extra entry accepted while main stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_read_data  <= '0;
      r_skid_alu_result <= '0;
      r_skid_dest_reg   <= '0;
      r_skid_wb         <= '0;
    end else if (flush) begin
      r_skid_wb         <= '0;
    end else if (w_load_skid) begin
      r_skid_read_data  <= in_read_data;
      r_skid_alu_result <= in_alu_result;
      r_skid_dest_reg   <= in_dest_reg;
      r_skid_wb         <= in_wb;
    end
  end

  assign in_ready       = r_in_ready;
  assign out_valid      = r_out_valid;
  assign out_read_data  = r_main_read_data;
  assign out_alu_result = r_main_alu_result;
  assign out_dest_reg   = r_main_dest_reg;
  assign out_wb         = r_out_valid ? r_main_wb : '0;

`ifdef MEMWB_STATS_EN
  logic [STAT_W-1:0] r_stall_count;

  // Saturating count of cycles where write-back holds off a valid entry;
  // only reset clears it so flushes do not lose history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_count != {STAT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + {{(STAT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_count = r_stall_count;
`else
  // Without statistics there is no stall counter and no extra state.
`endif

endmodule

// File: tb/tb_buffer_mem_wb_skid.sv
// tb_buffer_mem_wb_skid: directed and randomized checks of the MEM/WB skid
// buffer against a queue-based model (a 2-deep in-order FIFO whose ready
// reflects free space at the start of the cycle).
// Define MEMWB_STATS_EN to also check the saturating stall counter (STAT_W=4).

module tb_buffer_mem_wb_skid;

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic [1:0]  wb;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_read_data;
  logic [31:0] in_alu_result;
  logic [4:0]  in_dest_reg;
  logic [1:0]  in_wb;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_read_data;
  logic [31:0] out_alu_result;
  logic [4:0]  out_dest_reg;
  logic [1:0]  out_wb;
`ifdef MEMWB_STATS_EN
  localparam int STAT_MAX = 15;
  logic [3:0]  stall_count;
  int          stallModel;
`endif

  int     total = 0;
  int     bad   = 0;
  entry_t q[$];
  entry_t lastHead;
  entry_t cur;
  logic   curValid;
  bit     inTaken;

  buffer_mem_wb_skid #(
    .DATA_W(32),
    .REG_W (5),
    .WB_W  (2)
`ifdef MEMWB_STATS_EN
    ,
    .STAT_W(4)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_read_data  (in_read_data),
    .in_alu_result (in_alu_result),
    .in_dest_reg   (in_dest_reg),
    .in_wb         (in_wb),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_read_data (out_read_data),
    .out_alu_result(out_alu_result),
    .out_dest_reg  (out_dest_reg),
    .out_wb        (out_wb)
`ifdef MEMWB_STATS_EN
    ,
    .stall_count   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports the failure.
  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the queue model.
  task automatic checkOutput(input string tag);
    logic expValid;
    expValid = (q.size() > 0);
    checkEq({tag, ".out_valid"}, 64'(out_valid), 64'(expValid));
    checkEq({tag, ".in_ready"}, 64'(in_ready), 64'(q.size() < 2));
    checkEq({tag, ".out_wb"}, 64'(out_wb), expValid ? 64'(lastHead.wb) : 64'd0);
    checkEq({tag, ".out_read_data"}, 64'(out_read_data), 64'(lastHead.rd));
    checkEq({tag, ".out_alu_result"}, 64'(out_alu_result), 64'(lastHead.alu));
    checkEq({tag, ".out_dest_reg"}, 64'(out_dest_reg), 64'(lastHead.dest));
`ifdef MEMWB_STATS_EN
    checkEq({tag, ".stall_count"}, 64'(stall_count), 64'(stallModel));
`endif
  endtask

  task automatic modelReset();
    q.delete();
    lastHead = '0;
    inTaken  = 1'b1;
`ifdef MEMWB_STATS_EN
    stallModel = 0;
`endif
  endtask

  // Advance the model over one rising edge using the inputs now applied.
  task automatic modelStep();
    entry_t e;
    bit expValid, expReady, inFire, outFire;
    expValid = (q.size() > 0);
    expReady = (q.size() < 2);
    inFire   = in_valid && expReady;
    outFire  = expValid && out_ready;
`ifdef MEMWB_STATS_EN
    if (expValid && !out_ready && stallModel < STAT_MAX) stallModel++;
`endif
    e.rd   = in_read_data;
    e.alu  = in_alu_result;
    e.dest = in_dest_reg;
    e.wb   = in_wb;
    if (flush) begin
      q.delete();
    end else begin
      if (outFire) void'(q.pop_front());
      if (inFire) q.push_back(e);
    end
    if (q.size() > 0) lastHead = q[0];
    inTaken = inFire || flush;
  endtask

  // Drive one cycle of inputs, clock it, update the model and check.
  task automatic applyStimulus(input logic v, input logic [31:0] rd, input logic [31:0] alu,
                               input logic [4:0] dest, input logic [1:0] wb,
                               input logic ordy, input logic fl, input string tag);
    in_valid      = v;
    in_read_data  = rd;
    in_alu_result = alu;
    in_dest_reg   = dest;
    in_wb         = wb;
    out_ready     = ordy;
    flush         = fl;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    applyIdle();
    modelReset();
    #12;
    $display("[TB] reset state");
    checkOutput("reset");
    checkEq("reset.out_valid_const", 64'(out_valid), 64'd0);
    checkEq("reset.in_ready_const", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    $display("[TB] single transfer");
    applyStimulus(1'b1, 32'hDEADBEEF, 32'h10, 5'd9, 2'b11, 1'b1, 1'b0, "single");
    checkEq("single.rd", 64'(out_read_data), 64'hDEADBEEF);
    checkEq("single.alu", 64'(out_alu_result), 64'h10);
    checkEq("single.dest", 64'(out_dest_reg), 64'd9);
    checkEq("single.wb", 64'(out_wb), 64'd3);
    checkEq("single.valid", 64'(out_valid), 64'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0, "single_after");
    checkEq("single_after.valid", 64'(out_valid), 64'd0);
    checkEq("single_after.wb", 64'(out_wb), 64'd0);

    $display("[TB] back-to-back stream");
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, $urandom, 32'(i), 5'($urandom), 2'($urandom), 1'b1, 1'b0, "stream");
      checkEq("stream.alu", 64'(out_alu_result), 64'(i));
      checkEq("stream.in_ready", 64'(in_ready), 64'd1);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0, "stream_end");

    $display("[TB] backpressure");
    applyStimulus(1'b1, 32'h1111, 32'hA, 5'd1, 2'b01, 1'b0, 1'b0, "bp_a");
    applyStimulus(1'b1, 32'h2222, 32'hB, 5'd2, 2'b10, 1'b0, 1'b0, "bp_b");
    checkEq("bp_full.in_ready", 64'(in_ready), 64'd0);
    checkEq("bp_full.alu", 64'(out_alu_result), 64'hA);
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, "bp_hold");
    checkEq("bp_hold.alu", 64'(out_alu_result), 64'hA);
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0, "bp_drain1");
    checkEq("bp_drain1.alu", 64'(out_alu_result), 64'hB);
    checkEq("bp_drain1.in_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0, "bp_drain2");
    checkEq("bp_drain2.valid", 64'(out_valid), 64'd0);

    $display("[TB] flush while full");
    applyStimulus(1'b1, 32'h3333, 32'hA, 5'd3, 2'b11, 1'b0, 1'b0, "fl_a");
    applyStimulus(1'b1, 32'h4444, 32'hB, 5'd4, 2'b11, 1'b0, 1'b0, "fl_b");
    applyStimulus(1'b1, 32'h5555, 32'hC, 5'd5, 2'b11, 1'b0, 1'b1, "fl_flush");
    checkEq("fl_flush.valid", 64'(out_valid), 64'd0);
    checkEq("fl_flush.wb", 64'(out_wb), 64'd0);
    checkEq("fl_flush.in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0, "fl_idle");
      checkEq("fl_idle.valid", 64'(out_valid), 64'd0);
    end

    $display("[TB] async reset mid-stream");
    applyStimulus(1'b1, 32'h6666, 32'h21, 5'd6, 2'b01, 1'b0, 1'b0, "ar_1");
    applyStimulus(1'b1, 32'h7777, 32'h22, 5'd7, 2'b10, 1'b0, 1'b0, "ar_2");
    #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("ar_reset");
    checkEq("ar_reset.valid", 64'(out_valid), 64'd0);
    checkEq("ar_reset.alu", 64'(out_alu_result), 64'd0);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h8888, 32'h30, 5'd8, 2'b11, 1'b1, 1'b0, "ar_after");
    checkEq("ar_after.valid", 64'(out_valid), 64'd1);
    checkEq("ar_after.alu", 64'(out_alu_result), 64'h30);

    $display("[TB] randomized traffic");
    curValid = 1'b0;
    cur      = '0;
    inTaken  = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (!(curValid && !inTaken)) begin
        curValid = ($urandom_range(0, 3) != 0);
        cur.rd   = $urandom;
        cur.alu  = $urandom;
        cur.dest = 5'($urandom);
        cur.wb   = 2'($urandom);
      end
      applyStimulus(curValid, cur.rd, cur.alu, cur.dest, cur.wb,
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), "rand");
    end

`ifdef MEMWB_STATS_EN
    $display("[TB] stall counter saturation");
    @(negedge clk);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkEq("stat_reset", 64'(stall_count), 64'd0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h9999, 32'h40, 5'd10, 2'b01, 1'b0, 1'b0, "stat_load");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, "stat_hold");
    end
    checkEq("stat_sat", 64'(stall_count), 64'd15);
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b1, "stat_flush");
    checkEq("stat_after_flush", 64'(stall_count), 64'd15);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Quiet input values used while the DUT sits in reset.
  task automatic applyIdle();
    flush         = 1'b0;
    in_valid      = 1'b0;
    in_read_data  = '0;
    in_alu_result = '0;
    in_dest_reg   = '0;
    in_wb         = '0;
    out_ready     = 1'b0;
  endtask

endmodule

// File: doc/buffer_mem_wb_skid.md
Name: buffer_mem_wb_skid

Overview:
- Parametrised next-generation MEM/WB pipeline buffer, placed between the data-memory stage and the register-file write-back.
- Registers the read data, ALU result, destination register and WB control of one instruction.
- Adds a valid/ready handshake with a 2-entry skid buffer, a synchronous flush and WB-control gating on bubbles.
- Gives full throughput of 1 instruction/cycle with registered in_ready, so stalls from write-back never form a combinational path back into MEM.

Parameters:
DATA_W, 32, width of read data and ALU result
REG_W, 5, width of destination register index
WB_W, 2, width of write-back control field
STAT_W, 16, width of stall counter (only with MEMWB_STATS_EN)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous flush, discards all held entries
in_valid  input  1  MEM stage presents an instruction
in_ready  output  1  buffer can accept (registered)
in_read_data  input  DATA_W  data memory read value
in_alu_result  input  DATA_W  ALU result / memory address
in_dest_reg  input  REG_W  destination register (mux output)
in_wb  input  WB_W  write-back control
out_valid  output  1  output entry valid
out_ready  input  1  write-back stage consumes entry
out_read_data  output  DATA_W  registered read data
out_alu_result  output  DATA_W  registered ALU result
out_dest_reg  output  REG_W  registered destination
out_wb  output  WB_W  registered WB control, forced 0 when out_valid=0
stall_count  output  STAT_W  stall cycles (only with MEMWB_STATS_EN)

Behaviour:
- Reset (rst_n low, async): all entries invalid; out_valid=0, in_ready=1; all data/control outputs 0; stall_count=0.
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Source holds its data while in_valid=1 and in_ready=0.
- Storage: main register (drives outputs) and skid register. Three states:
  - EMPTY: in_fire -> ONE, main loads input; out_valid=1 next cycle (latency 1).
  - ONE:
    - in_fire & out_fire -> ONE, main loads input.
    - out_fire only -> EMPTY.
    - in_fire only -> FULL, skid loads input, in_ready=0 next cycle.
    - neither -> hold.
  - FULL: in_ready=0, so no in_fire.
    - out_fire -> ONE, main loads skid contents, in_ready=1 next cycle.
    - otherwise hold.
- in_ready is registered: 1 in EMPTY/ONE, 0 in FULL.
- Order preserved; no entry is ever dropped or duplicated.
- out_wb = main.wb when out_valid, else 0, so bubbles never write the register file.
- out_read_data, out_alu_result and out_dest_reg keep their last loaded value during bubbles.
- flush (sync, highest priority):
  - Next state EMPTY, out_valid=0, in_ready=1, stored wb fields cleared.
  - An input presented in the flush cycle is discarded even if in_valid=1 and in_ready=1.
  - out_fire in the flush cycle still counts as consumed.
- Reset mid-operation: immediate return to reset values regardless of state.
- Widths are straight pass-through; no arithmetic on data.

Optional Feature:
- MEMWB_STATS_EN defined:
  - stall_count increments by 1 each cycle with out_valid=1 and out_ready=0.
  - Saturates at 2^STAT_W-1.
  - Cleared by reset only, not by flush.
- Not defined:
  - stall_count port absent; no counter logic.

Test Plan:
- Reset then single transfer: in_valid=1 for one cycle with read_data=0xDEADBEEF, alu=0x00000010, dest=5'd9, wb=2'b11, out_ready=1 -> next cycle out_valid=1 with exactly those values; following cycle out_valid=0, out_wb=0.
- Back-to-back stream: 8 instructions with alu=1..8, out_ready held 1 -> outputs alu=1..8 on consecutive cycles, in_ready constantly 1.
- Backpressure: out_ready=0 while sending alu=0xA, 0xB -> state FULL, in_ready=0, out_alu_result=0xA held; raise out_ready -> 0xA then 0xB, in_ready returns 1 one cycle after the first out_fire.
- Flush in FULL with in_valid=1 (alu=0xC) -> next cycle out_valid=0, out_wb=0, in_ready=1; 0xA, 0xB and 0xC never appear.
- Async reset asserted mid-stream (not on a clock edge) -> outputs 0, out_valid=0 immediately; after release, first accepted instruction appears 1 cycle later.
- MEMWB_STATS_EN with STAT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_count=15 (saturated); flush leaves it at 15.
